scan_mux_seq: RTL and testbench
===============================

// Module: scan_mux_seq
// PURPOSE
//  Parametrised N:1 channel multiplexer with registered valid/ready output and built-in sweep sequencer.
//  Manual mode: forwards the channel chosen by sel_in.
//  Scan mode: a single start pulse walks channels 0..NCH-1, emitting one beat per channel with
//  programmable dwell, then pulses done. Feeds downstream logging/display logic that consumes one word per beat.
// PARAMETERS
//  WIDTH   8  data width per channel
//  NCH     8  number of input channels (2..16)
//  SELW    3  select width, must equal clog2(NCH)
//  DWELL   1  min cycles between scan beats (>=1); 1 = back-to-back
// PORTS
//  clk       in   1           rising-edge clock
//  rst       in   1           synchronous reset, active-high
//  in_bus    in   NCH*WIDTH   channel k = in_bus[k*WIDTH +: WIDTH]
//  mode      in   1           0 manual, 1 scan; sampled only in IDLE
//  sel_in    in   SELW        manual channel select
//  start     in   1           scan start pulse; honoured only in IDLE with mode=1
//  out_data  out  WIDTH       registered selected data
//  out_ch    out  SELW        channel index of out_data
//  out_valid out  1           beat valid
//  out_ready in   1           downstream accept
//  busy      out  1           1 while scan in progress (SCAN or DRAIN)
//  done      out  1           1-cycle pulse when last scan beat is accepted
//  sel_err   out  1           1-cycle pulse: manual sel_in >= NCH
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state=IDLE; out_data=0, out_ch=0, out_valid=0, busy=0, done=0,
//  sel_err=0; scan counter=0, dwell counter=0. Reset mid-scan aborts immediately; no done pulse.
//  Slot free = !out_valid || out_ready. A beat transfers on an edge with out_valid && out_ready.
//  While out_valid && !out_ready: out_data/out_ch held stable; no new capture.
//  Capture: data sampled from in_bus at the capture edge; visible on out_* the next cycle (1-cycle latency).
//  FSM:
//   IDLE:
//    mode=0: every cycle with slot free, capture channel sel_in, out_valid=1.
//     If sel_in>=NCH: out_data=0, out_ch=sel_in[SELW-1:0], sel_err pulses.
//     Nothing is captured when slot is not free; sel_in changes then are ignored.
//    mode=1: out_valid drops after the pending beat is accepted.
//     start=1 -> SCAN, ch=0, dwell=0, busy=1. Pending manual beat must drain first
//     (start with slot not free is ignored).
//   SCAN: when slot free and dwell==0: capture channel ch, out_valid=1, dwell=DWELL-1.
//    ch==NCH-1 -> DRAIN; else ch=ch+1. When dwell!=0: dwell decrements each cycle,
//    regardless of ready. If slot is free and no capture occurs this cycle, out_valid=0.
//   DRAIN: wait for last beat transfer; on it: out_valid=0, done=1 (one cycle), busy=0 -> IDLE.
//  start while busy is ignored; mode/sel_in changes during SCAN/DRAIN are ignored.
//  ch counter never wraps past NCH-1; a scan is exactly NCH beats in order 0..NCH-1.
//  Throughput with ready=1 and DWELL=1: one beat per cycle; scan done pulse at cycle NCH+1 after start.
// TESTING
//  T1 manual: WIDTH=8,NCH=8, ch k = 8'h80>>k, ready=1, sel_in 0..7 every 10 cyc
//     -> out_data 80,40,20,10,08,04,02,01, one cycle after each sel change; out_ch matches.
//  T2 backpressure: manual sel=3, ready=0 for 5 cyc, change sel to 5
//     -> out_data stays 10/out_ch 3 until ready=1; then 04.
//  T3 scan: mode=1, start pulse, ready=1, DWELL=1
//     -> 8 consecutive beats ch 0..7 data 80..01, busy high 9 cyc, done single pulse after ch 7 accepted.
//  T4 scan with DWELL=3 and ready toggling 1/0 each cycle
//     -> beats in order, no loss/duplicate, >=3 cycles between captures; start mid-scan ignored.
//  T5 reset mid-scan after ch 4 captured
//     -> next cycle out_valid=0, busy=0, no done; new start restarts at ch 0.
//  T6 NCH=5,SELW=3: manual sel_in=6 -> sel_err pulse, out_data=0; scan emits ch 0..4 only.

Source files
------------

// File: rtl/scan_mux_seq.sv
`default_nettype none
// ============================================================================
//  Module      : scan_mux_seq
//  Description : N:1 channel multiplexer with a registered valid/ready output
//                and a built-in sweep sequencer.
//                Manual mode forwards the channel picked by sel_in_i on every
//                free output slot. Scan mode walks channels 0..NCH-1 once per
//                start pulse, one beat per channel with a programmable
//                minimum dwell between captures, then pulses done_o.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                in_bus_i       - packed channels, ch k = [k*WIDTH +: WIDTH]
//                mode_i         - 0 manual, 1 scan (looked at only in IDLE)
//                sel_in_i       - manual channel select
//                start_i        - scan start pulse
//                out_data_o/out_ch_o/out_valid_o/out_ready_i - output beat
//                busy_o         - scan in progress
//                done_o         - 1-cycle pulse after last scan beat accepted
//                sel_err_o      - 1-cycle pulse with an out-of-range capture
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_mux_seq #(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = 3,
    parameter int DWELL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_bus_i,
    input  logic                 mode_i,
    input  logic [SELW-1:0]      sel_in_i,
    input  logic                 start_i,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [SELW-1:0]      out_ch_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 sel_err_o
);

    // Dwell counter only ever holds DWELL-1 down to 0.
    localparam int              DWW            = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DWW-1:0]  c_DWELL_RELOAD = DWW'(DWELL - 1);
    localparam logic [SELW-1:0] c_LAST_CH      = SELW'(NCH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SCAN  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic [SELW-1:0]  ch_q,      ch_d;
    logic             valid_q,   valid_d;
    logic             done_q,    done_d;
    logic             sel_err_q, sel_err_d;
    logic [SELW-1:0]  scan_ch_q, scan_ch_d;
    logic [DWW-1:0]   dwell_q,   dwell_d;

    logic [WIDTH-1:0] w_ch [NCH];
    logic [SELW-1:0]  w_mux_sel;
    logic [WIDTH-1:0] w_mux_data;
    logic             w_sel_hit;
    logic             w_slot_free;
    logic             w_scan_fire;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign w_ch[k] = in_bus_i[k*WIDTH +: WIDTH];
    end

    assign w_slot_free = !valid_q || out_ready_i;
    assign w_mux_sel   = (state_q == c_ST_SCAN) ? scan_ch_q : sel_in_i;
    assign w_scan_fire = (state_q == c_ST_SCAN) && w_slot_free && (dwell_q == '0);

    // Decoded mux: a select that matches no channel yields zero data and
    // leaves w_sel_hit low, which is what flags a manual select error.
    always_comb begin
        w_mux_data = '0;
        w_sel_hit  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (w_mux_sel == SELW'(k)) begin
                w_mux_data = w_ch[k];
                w_sel_hit  = 1'b1;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_ST_IDLE;
            data_q    <= '0;
            ch_q      <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
            scan_ch_q <= '0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            ch_q      <= ch_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            sel_err_q <= sel_err_d;
            scan_ch_q <= scan_ch_d;
            dwell_q   <= dwell_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (mode_i && start_i && w_slot_free) state_d = c_ST_SCAN;
            c_ST_SCAN:  if (w_scan_fire && (scan_ch_q == c_LAST_CH)) state_d = c_ST_DRAIN;
            c_ST_DRAIN: if (valid_q && out_ready_i) state_d = c_ST_IDLE;
            default:    state_d = c_ST_IDLE;
        endcase
    end

    // Datapath / counter next values
    always_comb begin
        data_d    = data_q;
        ch_d      = ch_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        sel_err_d = 1'b0;
        scan_ch_d = scan_ch_q;
        dwell_d   = dwell_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_slot_free) begin
                    if (!mode_i) begin
                        data_d    = w_mux_data;
                        ch_d      = sel_in_i;
                        valid_d   = 1'b1;
                        sel_err_d = !w_sel_hit;
                    end else begin
                        // Scan mode idles with no beat; a start only counts
                        // once any manual beat has been accepted.
                        valid_d = 1'b0;
                        if (start_i) begin
                            scan_ch_d = '0;
                            dwell_d   = '0;
                        end
                    end
                end
            end
            c_ST_SCAN: begin
                if (w_scan_fire) begin
                    data_d  = w_mux_data;
                    ch_d    = scan_ch_q;
                    valid_d = 1'b1;
                    dwell_d = c_DWELL_RELOAD;
                    if (scan_ch_q != c_LAST_CH) begin
                        scan_ch_d = scan_ch_q + SELW'(1);
                    end
                end else begin
                    // Dwell runs down independently of downstream ready.
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - DWW'(1);
                    end
                    if (w_slot_free) begin
                        valid_d = 1'b0;
                    end
                end
            end
            c_ST_DRAIN: begin
                if (valid_q && out_ready_i) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        out_data_o  = data_q;
        out_ch_o    = ch_q;
        out_valid_o = valid_q;
        busy_o      = (state_q != c_ST_IDLE);
        done_o      = done_q;
        sel_err_o   = sel_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_mux_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_mux_seq
//  Description : Directed self-checking bench for scan_mux_seq. Three
//                instances share stimulus: A (NCH=8, DWELL=1),
//                B (NCH=8, DWELL=3) and C (NCH=5, DWELL=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_mux_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_bus;
    logic        mode;
    logic [2:0]  sel;
    logic        start;
    logic        ready;

    logic [7:0] a_data, b_data, c_data;
    logic [2:0] a_ch,   b_ch,   c_ch;
    logic       a_valid, b_valid, c_valid;
    logic       a_busy,  b_busy,  c_busy;
    logic       a_done,  b_done,  c_done;
    logic       a_err,   b_err,   c_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scan_mux_seq #(.WIDTH(8), .NCH(8), .SELW(3), .DWELL(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_bus_i(in_bus), .mode_i(mode), .sel_in_i(sel),
        .start_i(start), .out_data_o(a_data), .out_ch_o(a_ch), .out_valid_o(a_valid),
        .out_ready_i(ready), .busy_o(a_busy), .done_o(a_done), .sel_err_o(a_err)
    );

    scan_mux_seq #(.WIDTH(8), .NCH(8), .SELW(3), .DWELL(3)) u_dut_b (
        .clk(clk), .rst(rst), .in_bus_i(in_bus), .mode_i(mode), .sel_in_i(sel),
        .start_i(start), .out_data_o(b_data), .out_ch_o(b_ch), .out_valid_o(b_valid),
        .out_ready_i(ready), .busy_o(b_busy), .done_o(b_done), .sel_err_o(b_err)
    );

    scan_mux_seq #(.WIDTH(8), .NCH(5), .SELW(3), .DWELL(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_bus_i(in_bus[39:0]), .mode_i(mode), .sel_in_i(sel),
        .start_i(start), .out_data_o(c_data), .out_ch_o(c_ch), .out_valid_o(c_valid),
        .out_ready_i(ready), .busy_o(c_busy), .done_o(c_done), .sel_err_o(c_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] chan_val(input int k);
        logic [7:0] v;
        v = 8'h80;
        return v >> k;
    endfunction

    // T4 scoreboard state
    int   cyc;
    int   idx;
    int   ndone;
    int   last_cap;
    logic prev_v;
    logic prev_x;
    logic xfer;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 8; k++) in_bus[k*8 +: 8] = chan_val(k);
        mode  = 1'b0;
        sel   = 3'd0;
        ready = 1'b1;
        start = 1'b0;
        rst   = 1'b1;
        #1;

        // Reset state
        do_reset();
        check_eq("rst_valid", a_valid, 0);
        check_eq("rst_data",  a_data,  0);
        check_eq("rst_ch",    a_ch,    0);
        check_eq("rst_busy",  a_busy,  0);
        check_eq("rst_done",  a_done,  0);
        check_eq("rst_err",   a_err,   0);

        // T1 manual select, 10 cycles per channel, one cycle latency
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            if (k > 0) check_eq("t1_latency_old", a_data, chan_val(k - 1));
            tick();
            check_eq("t1_data",  a_data,  chan_val(k));
            check_eq("t1_ch",    a_ch,    k);
            check_eq("t1_valid", a_valid, 1);
            for (int j = 0; j < 9; j++) tick();
        end

        // T2 backpressure
        sel = 3'd3;
        tick();
        check_eq("t2_pre_data", a_data, 8'h10);
        ready = 1'b0;
        tick();
        sel = 3'd5;
        for (int j = 0; j < 5; j++) begin
            tick();
            check_eq("t2_hold_data",  a_data,  8'h10);
            check_eq("t2_hold_ch",    a_ch,    3);
            check_eq("t2_hold_valid", a_valid, 1);
        end
        ready = 1'b1;
        check_eq("t2_release_old", a_data, 8'h10);
        tick();
        check_eq("t2_new_data", a_data, 8'h04);
        check_eq("t2_new_ch",   a_ch,   5);

        // T3 back-to-back scan on A
        do_reset();
        mode  = 1'b1;
        ready = 1'b1;
        tick();
        check_eq("t3_idle_valid", a_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t3_busy_start", a_busy,  1);
        check_eq("t3_valid_start", a_valid, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("t3_valid", a_valid, 1);
            check_eq("t3_ch",    a_ch,    k);
            check_eq("t3_data",  a_data,  chan_val(k));
            check_eq("t3_busy",  a_busy,  1);
            check_eq("t3_done_early", a_done, 0);
        end
        tick();
        check_eq("t3_done",       a_done,  1);
        check_eq("t3_busy_end",   a_busy,  0);
        check_eq("t3_valid_end",  a_valid, 0);
        tick();
        check_eq("t3_done_pulse", a_done,  0);

        // T4 DWELL=3 on B with ready toggling and a stray start mid-scan
        do_reset();
        mode  = 1'b1;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start    = 1'b0;
        idx      = 0;
        ndone    = 0;
        last_cap = -100;
        prev_v   = 1'b0;
        prev_x   = 1'b0;
        cyc      = 0;
        while (cyc < 300 && ndone == 0) begin
            ready = cyc[0];
            start = (cyc == 6);
            if (b_valid && (!prev_v || prev_x)) begin
                if (last_cap >= 0) check_eq("t4_gap_ge3", ((cyc - last_cap) >= 3), 1);
                last_cap = cyc;
            end
            xfer = b_valid && ready;
            if (xfer) begin
                check_eq("t4_ch",   b_ch,   idx);
                check_eq("t4_data", b_data, chan_val(idx));
                idx++;
            end
            if (b_done) ndone++;
            prev_v = b_valid;
            prev_x = xfer;
            tick();
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;
        check_eq("t4_done_seen", ndone, 1);
        check_eq("t4_beats",     idx,   8);
        check_eq("t4_busy_end",  b_busy, 0);
        check_eq("t4_done_pulse", b_done, 0);

        // T5 reset mid-scan on A
        do_reset();
        mode  = 1'b1;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        check_eq("t5_ch4",   a_ch,   4);
        check_eq("t5_data4", a_data, 8'h08);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_valid", a_valid, 0);
        check_eq("t5_busy",  a_busy,  0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check_eq("t5_no_done", a_done, 0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("t5_restart_ch",    a_ch,    0);
        check_eq("t5_restart_data",  a_data,  8'h80);
        check_eq("t5_restart_valid", a_valid, 1);

        // T6 NCH=5 on C: bad manual select, then a 5-beat scan
        do_reset();
        mode  = 1'b0;
        ready = 1'b1;
        sel   = 3'd6;
        tick();
        check_eq("t6_err",   c_err,   1);
        check_eq("t6_data",  c_data,  0);
        check_eq("t6_ch",    c_ch,    6);
        check_eq("t6_valid", c_valid, 1);
        sel = 3'd2;
        tick();
        check_eq("t6_err_clear", c_err,  0);
        check_eq("t6_data_ok",   c_data, 8'h20);
        mode = 1'b1;
        tick();
        check_eq("t6_idle_valid", c_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("t6_scan_ch",   c_ch,   k);
            check_eq("t6_scan_data", c_data, chan_val(k));
        end
        tick();
        check_eq("t6_done",      c_done,  1);
        check_eq("t6_valid_end", c_valid, 0);
        check_eq("t6_busy_end",  c_busy,  0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
